// File: rtl/neopixel_pkg.sv
// Shared types and constants for the NeoPixel (WS2812) strand driver.
//   color_idx_t : colour channel selector on the load port (2'b11 is reserved)
//   drv_state_t : driver FSM states
//   pixel_t     : one pixel in wire order, G in the MSBs, then R, then B
package neopixel_pkg;

    localparam int BITS_PER_PIXEL = 24;

    typedef enum logic [1:0] {
        CI_RED   = 2'b00,
        CI_BLUE  = 2'b01,
        CI_GREEN = 2'b10
    } color_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SEND  = 2'b01,
        LATCH = 2'b10
    } drv_state_t;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

endpackage

// File: rtl/neopixel_bit_encoder.sv
// Bit-period timer for the WS2812 NRZ code.
//   clock, reset_n : system clock, async active-low reset
//   start          : run enable; while low the phase counter sits at 0, so each
//                    rise starts a fresh bit period
//   bit_value      : value of the bit currently being sent
//   neo_data_next  : line level for this phase (registered by the caller)
//   bit_done       : high on the last phase of the bit period
module neopixel_bit_encoder #(
    parameter int T0H_CYC = 18,
    parameter int T1H_CYC = 35,
    parameter int BIT_CYC = 63
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    input  logic bit_value,
    output logic neo_data_next,
    output logic bit_done
);

    localparam int PHW = $clog2(BIT_CYC);

    logic [PHW-1:0] phase_q;
    logic [PHW-1:0] high_cyc;

    assign high_cyc      = bit_value ? PHW'(T1H_CYC) : PHW'(T0H_CYC);
    assign bit_done      = start && (phase_q == PHW'(BIT_CYC - 1));
    assign neo_data_next = start && (phase_q < high_cyc);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
        end else if (!start || bit_done) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_q + 1'b1;
        end
    end

endmodule

// File: rtl/neopixel_strand_driver.sv
// NeoPixel strand driver: double-buffered GRB frame, streamed MSB first from
// pixel 0, followed by a low latch period and a one-cycle frame_done pulse.
//   clock, reset_n : system clock, async active-low reset
//   color_level    : intensity to write
//   color_index    : 00=R, 01=B, 10=G, 11 reserved (load dropped)
//   pixel_index    : target pixel of a load
//   load_color     : write color_level into the shadow frame
//   send_it        : copy shadow to active and start a frame (IDLE only)
//   neo_data       : registered serial data to the strand
//   ready_to_load  : shadow frame writable (always)
//   ready_to_send  : send_it accepted this cycle
//   frame_done     : one-cycle pulse after the latch period
//
// state | meaning
// IDLE  | line low, waiting for send_it
// SEND  | shifting NBITS bits out of the active frame
// LATCH | line low for the reset/latch gap, then frame_done
module neopixel_strand_driver
    import neopixel_pkg::*;
#(
    parameter int NUM_PIXELS = 8,
    parameter int T0H_CYC    = 18,
    parameter int T1H_CYC    = 35,
    parameter int BIT_CYC    = 63,
    parameter int LATCH_CYC  = 2500,
    localparam int PW        = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [7:0]    color_level,
    input  logic [1:0]    color_index,
    input  logic [PW-1:0] pixel_index,
    input  logic          load_color,
    input  logic          send_it,
    output logic          neo_data,
    output logic          ready_to_load,
    output logic          ready_to_send,
    output logic          frame_done
);

    localparam int NBITS = BITS_PER_PIXEL * NUM_PIXELS;
    localparam int BIW   = $clog2(NBITS);
    localparam int LCW   = $clog2(LATCH_CYC + 1);

    drv_state_t     state_q, state_d;
    pixel_t         shadow_q [NUM_PIXELS];
    pixel_t         active_q [NUM_PIXELS];
    logic [NBITS-1:0] active_bits;
    logic [BIW-1:0] bit_idx_q;
    logic [LCW-1:0] latch_cnt_q;
    logic           send_accept;
    logic           frame_done_d;
    logic           load_ok;
    logic           enc_start;
    logic           enc_data;
    logic           bit_done;

    assign load_ok = load_color
                     && (color_index != 2'b11)
                     && (32'(pixel_index) < 32'(NUM_PIXELS));

    // Shadow takes loads in every state; the copy on send_it reads the
    // pre-edge shadow, so a same-cycle load only shows up in the next frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_PIXELS; p++) begin
                shadow_q[p] <= '0;
                active_q[p] <= '0;
            end
        end else begin
            if (send_accept) begin
                active_q <= shadow_q;
            end
            if (load_ok) begin
                case (color_index)
                    CI_RED:   shadow_q[pixel_index].r <= color_level;
                    CI_BLUE:  shadow_q[pixel_index].b <= color_level;
                    CI_GREEN: shadow_q[pixel_index].g <= color_level;
                    default:  ;
                endcase
            end
        end
    end

    // Flatten so that bit index k is simply active_bits[k]: pixel 0 first,
    // and within a pixel G7 first down to B0.
    always_comb begin
        active_bits = '0;
        for (int p = 0; p < NUM_PIXELS; p++) begin
            for (int i = 0; i < BITS_PER_PIXEL; i++) begin
                active_bits[p*BITS_PER_PIXEL + i] = active_q[p][BITS_PER_PIXEL-1-i];
            end
        end
    end

    assign enc_start = (state_q == SEND);

    neopixel_bit_encoder #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC)
    ) u_bit_encoder (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (enc_start),
        .bit_value     (active_bits[bit_idx_q]),
        .neo_data_next (enc_data),
        .bit_done      (bit_done)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        send_accept  = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (send_it) begin
                    send_accept = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (bit_done && (bit_idx_q == BIW'(NBITS - 1))) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                // The latch state spans LATCH_CYC+1 cycles because neo_data
                // lags the state by one register; this keeps the line low for
                // exactly LATCH_CYC clocks after the last bit as seen on the pin.
                if (latch_cnt_q == LCW'(LATCH_CYC)) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_idx_q   <= '0;
            latch_cnt_q <= '0;
            neo_data    <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            if (state_q == SEND && state_d == SEND) begin
                bit_idx_q <= bit_done ? bit_idx_q + 1'b1 : bit_idx_q;
            end else begin
                bit_idx_q <= '0;
            end
            if (state_q == LATCH && state_d == LATCH) begin
                latch_cnt_q <= latch_cnt_q + 1'b1;
            end else begin
                latch_cnt_q <= '0;
            end
            neo_data   <= enc_data;
            frame_done <= frame_done_d;
        end
    end

    assign ready_to_send = (state_q == IDLE);
    assign ready_to_load = 1'b1;

endmodule

// File: tb/tb_neopixel_strand_driver.sv
// Directed bench for neopixel_strand_driver with a 2-pixel strand and short
// timings (T0H=2, T1H=4, BIT=6, LATCH=10). Each frame is captured cycle by
// cycle after the send edge and decoded from pulse widths.
module tb_neopixel_strand_driver;

    localparam int NCAP     = 330;
    localparam int NB       = 48;
    localparam int DONE_CYC = 1 + NB*6 + 10;

    logic       clock;
    logic       reset_n;
    logic [7:0] color_level;
    logic [1:0] color_index;
    logic [0:0] pixel_index;
    logic       load_color;
    logic       send_it;
    logic       neo_data;
    logic       ready_to_load;
    logic       ready_to_send;
    logic       frame_done;

    int vectors;
    int miscompares;

    logic nd_cap [NCAP];
    logic fd_cap [NCAP];
    logic rs_cap [NCAP];
    logic rl_cap [NCAP];

    neopixel_strand_driver #(
        .NUM_PIXELS (2),
        .T0H_CYC    (2),
        .T1H_CYC    (4),
        .BIT_CYC    (6),
        .LATCH_CYC  (10)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .color_level   (color_level),
        .color_index   (color_index),
        .pixel_index   (pixel_index),
        .load_color    (load_color),
        .send_it       (send_it),
        .neo_data      (neo_data),
        .ready_to_load (ready_to_load),
        .ready_to_send (ready_to_send),
        .frame_done    (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic px, input logic [1:0] ci, input logic [7:0] lvl);
        pixel_index = px;
        color_index = ci;
        color_level = lvl;
        load_color  = 1'b1;
        tick();
        load_color  = 1'b0;
    endtask

    task automatic record(input int c);
        nd_cap[c] = neo_data;
        fd_cap[c] = frame_done;
        rs_cap[c] = ready_to_send;
        rl_cap[c] = ready_to_load;
    endtask

    // Sends one frame and checks it. inj_cycle=0 puts a load alongside the
    // send_it; inj_cycle>0 pulses a load plus send_it during that cycle.
    task automatic run_frame(input string tag, input logic [47:0] exp_bits,
                             input int inj_cycle, input logic ipx,
                             input logic [1:0] ici, input logic [7:0] ilv);
        logic [47:0] got;
        int bad, w, base, nd_late, fd_cnt, fd_first, rs_bad, rl_bad;
        logic ok;
        send_it = 1'b1;
        if (inj_cycle == 0) begin
            pixel_index = ipx; color_index = ici; color_level = ilv; load_color = 1'b1;
        end
        tick();
        record(0);
        send_it = 1'b0; load_color = 1'b0;
        for (int c = 1; c < NCAP; c++) begin
            tick();
            record(c);
            send_it = 1'b0; load_color = 1'b0;
            if (c == inj_cycle) begin
                pixel_index = ipx; color_index = ici; color_level = ilv;
                load_color = 1'b1; send_it = 1'b1;
            end
        end
        got = '0; bad = 0;
        for (int k = 0; k < NB; k++) begin
            base = 1 + 6*k;
            w = 0;
            for (int j = 0; j < 6; j++) w += int'(nd_cap[base+j]);
            ok = (w == 2) || (w == 4);
            for (int j = 0; j < 6; j++) if (nd_cap[base+j] !== (j < w)) ok = 1'b0;
            got[47-k] = (w == 4);
            if (!ok) bad++;
        end
        nd_late = 0; fd_cnt = 0; fd_first = -1; rs_bad = 0; rl_bad = 0;
        for (int c = NB*6 + 1; c < NCAP; c++) if (nd_cap[c] !== 1'b0) nd_late++;
        for (int c = 0; c < NCAP; c++) begin
            if (fd_cap[c] === 1'b1) begin
                fd_cnt++;
                if (fd_first < 0) fd_first = c;
            end
            if (rl_cap[c] !== 1'b1) rl_bad++;
        end
        for (int c = 0; c < DONE_CYC; c++) if (rs_cap[c] !== 1'b0) rs_bad++;
        chk({tag, "_first_low"},     64'(nd_cap[0]), 64'(0));
        chk({tag, "_bits"},          64'(got), 64'(exp_bits));
        chk({tag, "_bad_periods"},   64'(bad), 64'(0));
        chk({tag, "_latch_high"},    64'(nd_late), 64'(0));
        chk({tag, "_done_cycle"},    64'(fd_first), 64'(DONE_CYC));
        chk({tag, "_done_pulses"},   64'(fd_cnt), 64'(1));
        chk({tag, "_rts_busy"},      64'(rs_bad), 64'(0));
        chk({tag, "_rts_after"},     64'(rs_cap[DONE_CYC]), 64'(1));
        chk({tag, "_rtl_always"},    64'(rl_bad), 64'(0));
    endtask

    initial begin
        int nd_hi, rs_lo, rl_lo, fd_hi;
        vectors = 0; miscompares = 0;
        reset_n = 1'b0; color_level = '0; color_index = '0; pixel_index = '0;
        load_color = 1'b0; send_it = 1'b0;
        #2;
        chk("rst_neo",  64'(neo_data), 64'(0));
        chk("rst_rts",  64'(ready_to_send), 64'(1));
        chk("rst_rtl",  64'(ready_to_load), 64'(1));
        chk("rst_done", 64'(frame_done), 64'(0));
        repeat (3) tick();
        reset_n = 1'b1;

        // 1: idle with no stimulus
        nd_hi = 0; rs_lo = 0; rl_lo = 0; fd_hi = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (neo_data !== 1'b0) nd_hi++;
            if (ready_to_send !== 1'b1) rs_lo++;
            if (ready_to_load !== 1'b1) rl_lo++;
            if (frame_done !== 1'b0) fd_hi++;
        end
        chk("idle_neo",  64'(nd_hi), 64'(0));
        chk("idle_rts",  64'(rs_lo), 64'(0));
        chk("idle_rtl",  64'(rl_lo), 64'(0));
        chk("idle_done", 64'(fd_hi), 64'(0));

        // 2: basic frame
        load(1'b0, 2'b10, 8'hA5);
        load(1'b0, 2'b00, 8'h00);
        load(1'b0, 2'b01, 8'hFF);
        load(1'b1, 2'b10, 8'h00);
        load(1'b1, 2'b00, 8'h00);
        load(1'b1, 2'b01, 8'h00);
        tick();
        // 3: load px0 R=3C and send_it mid-frame
        run_frame("f2", 48'hA500FF_000000, 50, 1'b0, 2'b00, 8'h3C);
        tick();
        run_frame("f3", 48'hA53CFF_000000, -1, 1'b0, 2'b00, 8'h00);
        tick();

        // 4: load px1 B=81 in the send_it cycle
        run_frame("f4a", 48'hA53CFF_000000, 0, 1'b1, 2'b01, 8'h81);
        tick();
        run_frame("f4b", 48'hA53CFF_000081, -1, 1'b0, 2'b00, 8'h00);
        tick();

        // 5: reserved colour index is dropped (pixel 2 is not encodable on a
        //    1-bit index with a 2-pixel strand)
        load(1'b0, 2'b11, 8'h77);
        load(1'b1, 2'b11, 8'h55);
        tick();
        run_frame("f5", 48'hA53CFF_000081, -1, 1'b0, 2'b00, 8'h00);
        tick();

        // 6: reset mid-bit
        send_it = 1'b1;
        tick();
        send_it = 1'b0;
        tick();
        tick();
        chk("pre_rst_high", 64'(neo_data), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_neo",  64'(neo_data), 64'(0));
        chk("mid_rst_rts",  64'(ready_to_send), 64'(1));
        chk("mid_rst_done", 64'(frame_done), 64'(0));
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_rts", 64'(ready_to_send), 64'(1));
        run_frame("f6", 48'h000000_000000, -1, 1'b0, 2'b00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
